// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax normalisation stage.
// Exponent words arrive as {pos, mant}; exp_to_lin expands them to linear values.
package softmax_pkg;

  localparam int EXP_W  = 21;
  localparam int POS_W  = 5;
  localparam int MANT_W = 16;
  localparam int LIN_W  = 47;

  typedef struct packed {
    logic [POS_W-1:0]  pos;
    logic [MANT_W-1:0] mant;
  } exp_word_t;

  typedef enum logic [1:0] {
    COLLECT,
    DIVIDE,
    OUTPUT
  } norm_state_t;

  // mant is at most 16 bits and pos at most 31, so the result fits LIN_W
  function automatic logic [LIN_W-1:0] exp_to_lin(input exp_word_t e);
    return LIN_W'(e.mant) << e.pos;
  endfunction

endpackage

// File: rtl/softmax_norm_seq_div.sv
// Restoring unsigned divider: one load cycle resolves the top quotient bit,
// then ITER iterations resolve the rest. Quotient is held until the next start.
module seq_div #(
  parameter int DVD_W = 64,
  parameter int DVS_W = 49,
  parameter int ITER  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [ITER:0]    quotient
);

  localparam int CNT_W = $clog2(ITER + 1);

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [ITER-1:0]  low_q, low_d;
  logic [ITER:0]    quo_q, quo_d;
  logic [DVD_W-1:0] hi_ext;
  logic [DVS_W:0]   trial;
  logic             ge;

  // The load step assumes dividend >> ITER is below twice the divisor, which
  // holds whenever the dividend element is part of the divisor sum.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    low_d  = low_q;
    quo_d  = quo_q;
    hi_ext = dividend >> ITER;
    trial  = {rem_q, low_q[ITER-1]};
    ge     = 1'b0;
    if (start) begin
      ge     = hi_ext >= DVD_W'(divisor);
      rem_d  = DVS_W'(hi_ext - (ge ? DVD_W'(divisor) : '0));
      low_d  = dividend[ITER-1:0];
      quo_d  = {ITER'(0), ge};
      cnt_d  = CNT_W'(ITER);
      busy_d = 1'b1;
    end else if (busy_q) begin
      ge    = trial >= {1'b0, divisor};
      rem_d = DVS_W'(ge ? trial - {1'b0, divisor} : trial);
      low_d = low_q << 1;
      quo_d = {quo_q[ITER-1:0], ge};
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      low_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      low_q  <= low_d;
      quo_q  <= quo_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/softmax_norm.sv
// Softmax normalisation: buffers N linearised exponents, sums them, and emits
// each element divided by the sum as Q0.OUT_W. SOFTMAX_NORM_ROUND_EN enables rounding.
module softmax_norm
  import softmax_pkg::*;
#(
  parameter int N     = 4,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_prob,
  output logic             out_last
);

  localparam int IDX_W = $clog2(N);
  localparam int SUM_W = LIN_W + $clog2(N);
  localparam int DVD_W = LIN_W + OUT_W + 1;

  norm_state_t      state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [LIN_W-1:0] buf_q [N];
  logic [LIN_W-1:0] buf_d [N];
  logic             div_wait_q, div_wait_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_prob_q, out_prob_d;
  logic             out_last_q, out_last_d;

  logic             in_fire, out_fire, div_start, div_done;
  logic [LIN_W-1:0] in_lin;
  logic [DVD_W-1:0] dividend;
  logic [OUT_W:0]   div_quo;

`ifdef SOFTMAX_NORM_ROUND_EN
  assign dividend = {1'b0, buf_q[rd_idx_q], OUT_W'(0)} + DVD_W'(sum_q >> 1);
`else
  assign dividend = {1'b0, buf_q[rd_idx_q], OUT_W'(0)};
`endif

  assign in_lin = exp_to_lin(exp_word_t'(in_exp));

  // Both streams transfer a word on a rising edge where valid and ready are
  // both high; out_valid, out_prob and out_last hold steady until that edge.
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    sum_d       = sum_q;
    buf_d       = buf_q;
    div_wait_d  = div_wait_q;
    out_valid_d = out_valid_q;
    out_prob_d  = out_prob_q;
    out_last_d  = out_last_q;
    div_start   = 1'b0;
    in_fire     = in_valid && in_ready_q;
    out_fire    = out_valid_q && out_ready;
    case (state_q)
      COLLECT: begin
        if (in_fire) begin
          buf_d[wr_idx_q] = in_lin;
          sum_d           = sum_q + SUM_W'(in_lin);
          if (wr_idx_q == IDX_W'(N - 1)) begin
            state_d  = DIVIDE;
            rd_idx_d = '0;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      DIVIDE: begin
        div_start  = !div_wait_q;
        div_wait_d = 1'b1;
        if (div_wait_q && div_done) begin
          div_wait_d  = 1'b0;
          state_d     = OUTPUT;
          out_valid_d = 1'b1;
          // A zero sum still runs the divider so timing matches, but its result is ignored
          out_prob_d  = (sum_q == '0) ? '0 :
                        (div_quo[OUT_W] ? '1 : div_quo[OUT_W-1:0]);
          out_last_d  = (rd_idx_q == IDX_W'(N - 1));
        end
      end
      OUTPUT: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (rd_idx_q == IDX_W'(N - 1)) begin
            state_d  = COLLECT;
            wr_idx_d = '0;
            rd_idx_d = '0;
            sum_d    = '0;
          end else begin
            state_d  = DIVIDE;
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
    in_ready_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      sum_q       <= '0;
      div_wait_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_prob_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      sum_q       <= sum_d;
      div_wait_q  <= div_wait_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_prob_q  <= out_prob_d;
      out_last_q  <= out_last_d;
    end
  end

  // Buffer slots are always written before they are read, so no reset is needed
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  seq_div #(
    .DVD_W(DVD_W),
    .DVS_W(SUM_W),
    .ITER (OUT_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (div_start),
    .dividend(dividend),
    .divisor (sum_q),
    .done    (div_done),
    .quotient(div_quo)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_prob  = out_prob_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_softmax_norm.sv
// Directed bench for softmax_norm: scoreboard of {last, prob} pushed at stimulus
// time and popped on each output handshake, plus latency and stall checks.
module tb_softmax_norm;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_prob;
  logic        out_last;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int hs_edge  = 0;
  logic prev_valid = 1'b0;
  logic mid_vec    = 1'b0;
  logic chk_ir     = 1'b0;
  logic [16:0] exp_q[$];

  softmax_norm #(.N(N), .OUT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_exp   (in_exp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_prob (out_prob),
    .out_last (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [46:0] l, input logic [48:0] s);
    logic [79:0] d, q;
    if (s == 49'd0) return 16'h0;
    d = {17'h0, l, 16'h0};
`ifdef SOFTMAX_NORM_ROUND_EN
    d = d + 80'(s >> 1);
`endif
    q = d / 80'(s);
    return (q > 80'hFFFF) ? 16'hFFFF : q[15:0];
  endfunction

  task automatic send(input logic [20:0] w);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_exp   = w;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("in_ready_timeout", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input logic [20:0] w0, input logic [20:0] w1,
                         input logic [20:0] w2, input logic [20:0] w3);
    logic [20:0] w[4];
    logic [46:0] l[4];
    logic [48:0] s;
    w = '{w0, w1, w2, w3};
    s = '0;
    for (int i = 0; i < N; i++) begin
      l[i] = 47'(w[i][15:0]) << w[i][20:16];
      s    = s + 49'(l[i]);
    end
    for (int i = 0; i < N; i++)
      exp_q.push_back({(i == N - 1) ? 1'b1 : 1'b0, model(l[i], s)});
    for (int i = 0; i < N; i++) send(w[i]);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", exp_q.size(), 32'h0);
    @(negedge clk);
  endtask

  // Output monitor: scoreboard compare, inter-output gap and in_ready return
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      mid_vec    = 1'b0;
      chk_ir     = 1'b0;
    end else begin
      if (chk_ir) begin
        chk("in_ready_return", {31'h0, in_ready}, 32'h1);
        chk_ir = 1'b0;
      end
      if (out_valid && !prev_valid && mid_vec)
        chk("gap_latency", cyc - hs_edge, 32'd18);
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          chk("prob_last", {15'h0, out_last, out_prob}, {15'h0, exp_q.pop_front()});
        end else begin
          checks++;
          failures++;
          $error("FAIL sb_underflow observed=%0h expected=none", {out_last, out_prob});
        end
        hs_edge = cyc + 1;
        mid_vec = !out_last;
        chk_ir  = out_last;
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    logic [15:0] hold_prob;
    logic        hold_last;
    int t;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_exp    = '0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_prob", {16'h0, out_prob}, 32'h0);
    chk("rst_out_last", {31'h0, out_last}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'h0, in_ready}, 32'h1);

    // Equal quarters with first-output latency
    run_vec({5'd16, 16'h8000}, {5'd16, 16'h8000}, {5'd16, 16'h8000}, {5'd16, 16'h8000});
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("first_latency", cyc - acc_cyc, 32'd18);
    wait_drain();

    // One dominant element saturates
    run_vec({5'd20, 16'h8000}, {5'd3, 16'h0}, {5'd7, 16'h0}, {5'd0, 16'h0});
    wait_drain();

    // Zero sum
    run_vec({5'd0, 16'h0}, {5'd31, 16'h0}, {5'd1, 16'h0}, {5'd9, 16'h0});
    wait_drain();

    // Backpressure on output 1
    run_vec({5'd4, 16'h0003}, {5'd4, 16'h0005}, {5'd4, 16'h0007}, {5'd4, 16'h0009});
    t = 0;
    while (!(exp_q.size() == 3 && !out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("stall_reach", exp_q.size(), 32'd3);
    #1 out_ready = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("stall_valid", {31'h0, out_valid}, 32'h1);
    hold_prob = out_prob;
    hold_last = out_last;
    repeat (5) begin
      @(negedge clk);
      chk("stall_prob", {16'h0, out_prob}, {16'h0, hold_prob});
      chk("stall_last", {31'h0, out_last}, {31'h0, hold_last});
      chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();

    // Reset after two accepted words, then a fresh vector
    send({5'd20, 16'hFFFF});
    send({5'd31, 16'hFFFF});
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    rst_n = 1'b1;
    run_vec({5'd10, 16'h1234}, {5'd10, 16'h1234}, {5'd10, 16'h1234}, {5'd10, 16'h1234});
    wait_drain();

    // Rounding-sensitive thirds
    run_vec({5'd0, 16'd2}, {5'd0, 16'd1}, {5'd0, 16'd0}, {5'd0, 16'd0});
    wait_drain();

    // Random vector
    run_vec({5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535))},
            {5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535))},
            {5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535))},
            {5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535))});
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
